cmd_dispatcher: RTL and testbench

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

---
 rtl/cmd_dispatcher.sv | 168 ++++++++++++++++
 tb/tb_cmd_dispatcher.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: queues host commands and issues them one at a time to the
// controller, tracking completion, timeouts and a finished-command count.
module cmd_dispatcher #(
    parameter int ADDR_WIDTH     = 10,
    parameter int BIG_N          = 30,
    parameter int FIFO_DEPTH     = 4,
    parameter int PTR_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_opcode,
    input  logic [ADDR_WIDTH-1:0] cmd_op1_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_op2_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_out_addr,
    input  logic [BIG_N-1:0]      cmd_noise,
    input  logic                  ctrl_done,
    output logic                  config_en,
    output logic [1:0]            opcode,
    output logic [ADDR_WIDTH-1:0] op1_base_addr,
    output logic [ADDR_WIDTH-1:0] op2_base_addr,
    output logic [ADDR_WIDTH-1:0] out_base_addr,
    output logic [BIG_N-1:0]      noise,
    output logic                  busy,
    output logic [PTR_WIDTH:0]    cmd_count,
    output logic                  op_complete,
    output logic [7:0]            done_count,
    output logic                  error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PTR_WIDTH:0] DEPTH = (PTR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef struct packed {
        logic [1:0]            op;
        logic [ADDR_WIDTH-1:0] a1;
        logic [ADDR_WIDTH-1:0] a2;
        logic [ADDR_WIDTH-1:0] ao;
        logic [BIG_N-1:0]      nz;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        COMPLETE
    } state_t;

    state_t               state;
    state_t               state_nx;
    entry_t               mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [TW-1:0]        tmo_cnt;
    logic                 push;
    logic                 pop;
    logic                 tmo_clr;
    logic                 tmo_inc;
    logic                 tmo_hit;
    logic                 err_set;
    logic                 done_inc;

    // Ready comes from the registered count only, so a pop never frees a
    // slot for a push in the same cycle.
    assign cmd_ready = cmd_count < DEPTH;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = state != IDLE;
    assign tmo_hit   = (tmo_cnt + TW'(1)) == TMAX;

    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        config_en   = 1'b0;
        op_complete = 1'b0;
        tmo_clr     = 1'b0;
        tmo_inc     = 1'b0;
        err_set     = 1'b0;
        done_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_count != '0) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                config_en = 1'b1;
                state_nx  = ARM;
            end
            // ctrl_done may still be high from the previous command here
            ARM: begin
                tmo_clr  = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (ctrl_done) begin
                    state_nx = COMPLETE;
                end else if (tmo_hit) begin
                    err_set  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            COMPLETE: begin
                op_complete = 1'b1;
                done_inc    = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cmd_count     <= '0;
            tmo_cnt       <= '0;
            done_count    <= '0;
            error         <= 1'b0;
            opcode        <= '0;
            op1_base_addr <= '0;
            op2_base_addr <= '0;
            out_base_addr <= '0;
            noise         <= '0;
        end else begin
            state <= state_nx;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
                {opcode, op1_base_addr, op2_base_addr,
                 out_base_addr, noise} <= mem[rd_ptr];
            end
            if (push && !pop) begin
                cmd_count <= cmd_count + (PTR_WIDTH + 1)'(1);
            end else if (pop && !push) begin
                cmd_count <= cmd_count - (PTR_WIDTH + 1)'(1);
            end
            if (tmo_clr) begin
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (err_set) begin
                error <= 1'b1;
            end
            if (done_inc) begin
                done_count <= done_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_opcode, cmd_op1_addr, cmd_op2_addr,
                            cmd_out_addr, cmd_noise};
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Scoreboard bench for cmd_dispatcher: directed scenarios plus a randomized
// stream checked against a queue-based reference model.
module tb_cmd_dispatcher;

    typedef struct packed {
        logic [1:0]  op;
        logic [9:0]  a1;
        logic [9:0]  a2;
        logic [9:0]  ao;
        logic [29:0] nz;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode;
    logic [9:0]  cmd_op1_addr;
    logic [9:0]  cmd_op2_addr;
    logic [9:0]  cmd_out_addr;
    logic [29:0] cmd_noise;
    logic        ctrl_done;
    logic        config_en;
    logic [1:0]  opcode;
    logic [9:0]  op1_base_addr;
    logic [9:0]  op2_base_addr;
    logic [9:0]  out_base_addr;
    logic [29:0] noise;
    logic        busy;
    logic [2:0]  cmd_count;
    logic        op_complete;
    logic [7:0]  done_count;
    logic        error;

    int   checks = 0;
    int   passes = 0;
    int   mode = 2;
    int   model_done = 0;
    cmd_t exp_cfg[$];
    logic [7:0] exp_done[$];

    cmd_dispatcher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cmd_opcode),
        .cmd_op1_addr  (cmd_op1_addr),
        .cmd_op2_addr  (cmd_op2_addr),
        .cmd_out_addr  (cmd_out_addr),
        .cmd_noise     (cmd_noise),
        .ctrl_done     (ctrl_done),
        .config_en     (config_en),
        .opcode        (opcode),
        .op1_base_addr (op1_base_addr),
        .op2_base_addr (op2_base_addr),
        .out_base_addr (out_base_addr),
        .noise         (noise),
        .busy          (busy),
        .cmd_count     (cmd_count),
        .op_complete   (op_complete),
        .done_count    (done_count),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.op = 2'($urandom);
        c.a1 = 10'($urandom);
        c.a2 = 10'($urandom);
        c.ao = 10'($urandom);
        c.nz = 30'($urandom);
        return c;
    endfunction

    // Drive one command and hold it until the handshake completes.
    task automatic send(input cmd_t c);
        bit acc = 1'b0;
        cmd_valid    = 1'b1;
        cmd_opcode   = c.op;
        cmd_op1_addr = c.a1;
        cmd_op2_addr = c.a2;
        cmd_out_addr = c.ao;
        cmd_noise    = c.nz;
        for (int i = 0; i < 3000 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("send_accept", acc, 1);
        if (acc) exp_cfg.push_back(c);
    endtask

    // ctrl_done high for the next cycle; op_complete must follow one later.
    task automatic pulse_done();
        @(posedge clk);
        #1;
        ctrl_done = 1'b1;
        exp_done.push_back(8'(model_done));
        model_done++;
        @(posedge clk);
        #1;
        ctrl_done = 1'b0;
        @(negedge clk);
        chk("op_complete_latency", op_complete, 1);
    endtask

    task automatic wait_cfg(input int lim);
        bit f = 1'b0;
        for (int i = 0; i < lim && !f; i++) begin
            @(negedge clk);
            f = config_en;
        end
        chk("config_en_seen", f, 1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            ok = exp_cfg.size() == 0 && exp_done.size() == 0 &&
                 !busy && cmd_count == 0;
        end
        chk("drain", ok, 1);
    endtask

    // Monitor: every configure and completion is matched to the scoreboard.
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (config_en) begin
                    chk("cfg_expected", exp_cfg.size() > 0, 1);
                    if (exp_cfg.size() > 0) begin
                        e = exp_cfg.pop_front();
                        chk("cfg_fields", {opcode, op1_base_addr,
                            op2_base_addr, out_base_addr, noise}, e);
                    end
                end
                if (op_complete) begin
                    chk("done_expected", exp_done.size() > 0, 1);
                    if (exp_done.size() > 0)
                        chk("done_count", done_count, exp_done.pop_front());
                end
            end
        end
    end

    // Controller model: answers each configure after a random delay.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (rst_n && config_en && mode == 0) begin
                d = $urandom_range(0, 10);
                @(posedge clk);
                repeat (d) @(posedge clk);
                pulse_done();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit   bad;
        int   g;
        cmd_t c;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_opcode = '0;
        cmd_op1_addr = '0;
        cmd_op2_addr = '0;
        cmd_out_addr = '0;
        cmd_noise = '0;
        ctrl_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_count", cmd_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_strobes", {config_en, op_complete}, 0);
        chk("rst_outputs", {opcode, op1_base_addr, op2_base_addr,
                            out_base_addr, noise}, 0);

        // single command latency
        @(posedge clk);
        #1;
        c = '{op: 2'd2, a1: 10'h010, a2: 10'h020, ao: 10'h030,
              nz: 30'h1234};
        send(c);
        @(negedge clk);
        chk("cfg_not_cycle1", config_en, 0);
        @(negedge clk);
        chk("cfg_cycle2", config_en, 1);
        repeat (7) @(posedge clk);
        pulse_done();
        @(negedge clk);
        chk("done_count_one", done_count, 1);
        chk("idle_after", busy, 0);

        // queue fill with a blocker held in WAIT
        @(posedge clk);
        #1;
        send(rnd_cmd());
        wait_cfg(10);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(rnd_cmd());
        chk("full_count", cmd_count, 4);
        chk("full_not_ready", cmd_ready, 0);
        bad = 1'b0;
        fork
            send(rnd_cmd());
            begin
                repeat (5) begin
                    @(negedge clk);
                    bad |= (cmd_count != 4) || cmd_ready;
                end
                chk("full_stall", bad, 0);
                mode = 0;
                pulse_done();
            end
        join
        drain();

        // stale ctrl_done through ISSUE and ARM is ignored
        mode = 2;
        @(posedge clk);
        #1;
        send(rnd_cmd());
        ctrl_done = 1'b1;
        wait_cfg(10);
        @(posedge clk);
        @(posedge clk);
        #1;
        ctrl_done = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bad |= op_complete || !busy;
        end
        chk("stale_done_ignored", bad, 0);
        pulse_done();
        drain();

        // timeout, then the queued command still issues
        @(posedge clk);
        #1;
        send(rnd_cmd());
        send(rnd_cmd());
        wait_cfg(10);
        bad = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            bad |= op_complete;
            if (i == 256) chk("err_before_limit", error, 0);
        end
        chk("no_complete_on_timeout", bad, 0);
        @(negedge clk);
        chk("err_at_limit", error, 1);
        chk("idle_after_timeout", busy, 0);
        @(negedge clk);
        chk("next_after_timeout", config_en, 1);
        @(posedge clk);
        pulse_done();
        drain();
        chk("err_sticky", error, 1);

        // reset during WAIT with two queued
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(rnd_cmd());
        chk("queued_two", cmd_count, 2);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", cmd_count, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_flags", {busy, error, config_en, op_complete}, 0);
        chk("mid_rst_done_count", done_count, 0);
        chk("mid_rst_outputs", {opcode, op1_base_addr, op2_base_addr,
                                out_base_addr, noise}, 0);
        exp_cfg.delete();
        exp_done.delete();
        model_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            bad |= config_en || op_complete || busy || (cmd_count != 0);
        end
        chk("quiet_after_reset", bad, 0);

        // randomized stream of 256 commands; done_count wraps
        mode = 0;
        for (int n = 0; n < 256; n++) begin
            g = $urandom_range(0, 3);
            if (g != 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            send(rnd_cmd());
        end
        drain();
        chk("model_total", model_done, 256);
        chk("done_wrap", done_count, 8'(model_done));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
